// File: rtl/eq_pkg.sv
// Shared amp power-sequencer types and default timing constants (also used by LED_drv).
package eq_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_WAIT_Q = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RAMP   = 3'd3,
    ST_RUN    = 3'd4,
    ST_FAULT  = 3'd5,
    ST_LOCKED = 3'd6
  } amp_state_t;

  localparam int unsigned VOL_W            = 12;
  localparam int unsigned DEF_STARTUP_CYC  = 250000;
  localparam int unsigned DEF_SETTLE_CYC   = 1024;
  localparam int unsigned DEF_RAMP_STEP    = 16;
  localparam int unsigned DEF_FLT_HOLD_CYC = 5000000;
  localparam int unsigned DEF_MAX_RETRY    = 3;
  localparam int unsigned DEF_CLR_CYC      = 50000000;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/vol_slew.sv
// Combinational step of cur toward tgt by at most step, never overshooting.
module vol_slew
  import eq_pkg::*;
(
  input  logic [VOL_W-1:0] cur,
  input  logic [VOL_W-1:0] tgt,
  input  logic [VOL_W-1:0] step,
  output logic [VOL_W-1:0] nxt
);

  logic [VOL_W:0]   up;
  logic [VOL_W-1:0] gap;

  always_comb begin
    up  = {1'b0, cur} + {1'b0, step};
    gap = '0;
    nxt = cur;
    if (tgt > cur) begin
      // Extra carry bit keeps the sum from wrapping past full scale before the clamp
      nxt = (up > {1'b0, tgt}) ? tgt : up[VOL_W-1:0];
    end else if (tgt < cur) begin
      gap = cur - tgt;
      nxt = (gap > step) ? (cur - step) : tgt;
    end
  end

endmodule

// File: rtl/amp_pwr_seq.sv
// Class-D amp power/fault sequencer: startup gating, soft ramp, volume slew, fault retry/lockout.
module amp_pwr_seq
  import eq_pkg::*;
#(
  parameter int unsigned STARTUP_CYC  = DEF_STARTUP_CYC,
  parameter int unsigned SETTLE_CYC   = DEF_SETTLE_CYC,
  parameter int unsigned RAMP_STEP    = DEF_RAMP_STEP,
  parameter int unsigned FLT_HOLD_CYC = DEF_FLT_HOLD_CYC,
  parameter int unsigned MAX_RETRY    = DEF_MAX_RETRY,
  parameter int unsigned CLR_CYC      = DEF_CLR_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Flt_n,
  input  logic              seq_low,
  input  logic              vld,
  input  logic [VOL_W-1:0]  vol_in,
  output logic              sht_dwn,
  output logic              mute,
  output logic [VOL_W-1:0]  vol_out,
  output logic [2:0]        state_o,
  output logic              locked
);

  localparam int unsigned TMR_W = $clog2(max3(STARTUP_CYC, SETTLE_CYC, FLT_HOLD_CYC) + 1);
  localparam int unsigned RUN_W = $clog2(CLR_CYC + 1);
  localparam int unsigned RTY_W = $clog2(MAX_RETRY + 1);

  localparam logic [TMR_W-1:0] STARTUP_LIM = TMR_W'(STARTUP_CYC - 1);
  localparam logic [TMR_W-1:0] SETTLE_LIM  = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] HOLD_LIM    = TMR_W'(FLT_HOLD_CYC - 1);
  localparam logic [RUN_W-1:0] CLR_LIM     = RUN_W'(CLR_CYC - 1);
  localparam logic [RTY_W-1:0] RTY_MAX     = RTY_W'(MAX_RETRY);

  amp_state_t       state, state_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic [RUN_W-1:0] run_cnt, run_nxt;
  logic [RTY_W-1:0] retry_cnt, retry_nxt;
  logic [VOL_W-1:0] vol_nxt, slew_nxt;
  logic             flt_s1, flt_s2, flt, fault_go;

  assign flt     = ~flt_s2;
  assign state_o = state;

  vol_slew u_slew (
    .cur  (vol_out),
    .tgt  (vol_in),
    .step (VOL_W'(RAMP_STEP)),
    .nxt  (slew_nxt)
  );

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    vol_nxt   = vol_out;
    retry_nxt = retry_cnt;
    run_nxt   = '0;
    fault_go  = 1'b0;
    unique case (state)
      ST_OFF: begin
        state_nxt = ST_WAIT_Q;
        tmr_nxt   = '0;
        vol_nxt   = '0;
      end
      ST_WAIT_Q: begin
        vol_nxt = '0;
        if (flt) begin
          tmr_nxt = '0;
        end else if (tmr >= STARTUP_LIM && seq_low) begin
          state_nxt = ST_SETTLE;
          tmr_nxt   = '0;
        end else if (tmr < STARTUP_LIM) begin
          tmr_nxt = tmr + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (flt) begin
          fault_go = 1'b1;
        end else if (tmr >= SETTLE_LIM) begin
          state_nxt = ST_RAMP;
          tmr_nxt   = '0;
        end else begin
          tmr_nxt = tmr + 1'b1;
        end
      end
      ST_RAMP: begin
        if (flt) begin
          fault_go = 1'b1;
        end else begin
          if (vld) vol_nxt = slew_nxt;
          if (vol_nxt == vol_in) state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (flt) begin
          fault_go = 1'b1;
        end else begin
          if (vld) vol_nxt = slew_nxt;
          run_nxt = (run_cnt < CLR_LIM) ? run_cnt + 1'b1 : run_cnt;
          if (run_cnt >= CLR_LIM) retry_nxt = '0;
        end
      end
      ST_FAULT: begin
        vol_nxt = '0;
        if (flt) begin
          tmr_nxt = '0;
        end else if (tmr >= HOLD_LIM) begin
          tmr_nxt   = '0;
          state_nxt = (retry_cnt >= RTY_MAX) ? ST_LOCKED : ST_WAIT_Q;
        end else begin
          tmr_nxt = tmr + 1'b1;
        end
      end
      ST_LOCKED: vol_nxt = '0;
      default:   state_nxt = ST_OFF;
    endcase
    // Fault entry overrides any vld/timer update decided above in the same cycle
    if (fault_go) begin
      state_nxt = ST_FAULT;
      tmr_nxt   = '0;
      vol_nxt   = '0;
      if (retry_cnt < RTY_MAX) retry_nxt = retry_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flt_s1    <= 1'b1;
      flt_s2    <= 1'b1;
      state     <= ST_OFF;
      tmr       <= '0;
      run_cnt   <= '0;
      retry_cnt <= '0;
      vol_out   <= '0;
      sht_dwn   <= 1'b1;
      mute      <= 1'b1;
      locked    <= 1'b0;
    end else begin
      flt_s1    <= Flt_n;
      flt_s2    <= flt_s1;
      state     <= state_nxt;
      tmr       <= tmr_nxt;
      run_cnt   <= run_nxt;
      retry_cnt <= retry_nxt;
      vol_out   <= vol_nxt;
      sht_dwn   <= !(state_nxt inside {ST_SETTLE, ST_RAMP, ST_RUN});
      mute      <= !(state_nxt inside {ST_RAMP, ST_RUN});
      locked    <= (state_nxt == ST_LOCKED);
    end
  end

endmodule

// File: tb/tb_amp_pwr_seq.sv
// Directed self-checking bench for amp_pwr_seq with shortened timing parameters.
module tb_amp_pwr_seq;

  logic        clk = 1'b0;
  logic        rst, Flt_n, seq_low, vld;
  logic [11:0] vol_in;
  logic        sht_dwn, mute, locked;
  logic [11:0] vol_out;
  logic [2:0]  state_o;

  always #5 clk = ~clk;

  amp_pwr_seq #(
    .STARTUP_CYC (100),
    .SETTLE_CYC  (8),
    .RAMP_STEP   (16),
    .FLT_HOLD_CYC(50),
    .MAX_RETRY   (3),
    .CLR_CYC     (400)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .Flt_n   (Flt_n),
    .seq_low (seq_low),
    .vld     (vld),
    .vol_in  (vol_in),
    .sht_dwn (sht_dwn),
    .mute    (mute),
    .vol_out (vol_out),
    .state_o (state_o),
    .locked  (locked)
  );

  typedef struct {
    logic [11:0] vin;
    logic        v;
    logic [11:0] exp_vol;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit auto_vld = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (auto_vld) vld = (cyc % 4 == 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic go_run(input string name);
    int n;
    n = 0;
    auto_vld = 1'b1;
    while (state_o != 3'd4 && n < 600) begin
      tick();
      n++;
    end
    chk(name, 32'(state_o), 32'd4);
  endtask

  task automatic do_fault(output logic [2:0] after);
    int n;
    Flt_n = 1'b0;
    repeat (5) tick();
    chk("fault_entered", 32'(state_o), 32'd5);
    Flt_n = 1'b1;
    n = 0;
    while (state_o == 3'd5 && n < 200) begin
      tick();
      n++;
    end
    after = state_o;
  endtask

  initial begin
    vec_t        vt[10];
    int          e, n, sht_fall, mute_fall, nsteps, bad, prev, lows, idx;
    logic [2:0]  s;

    vt[0] = '{12'h0F8, 1'b1, 12'd248};
    vt[1] = '{12'hFFF, 1'b1, 12'd264};
    vt[2] = '{12'hFFF, 1'b1, 12'd280};
    vt[3] = '{12'h100, 1'b1, 12'd264};
    vt[4] = '{12'h100, 1'b1, 12'd256};
    vt[5] = '{12'h100, 1'b1, 12'd256};
    vt[6] = '{12'h105, 1'b1, 12'd261};
    vt[7] = '{12'h0FF, 1'b1, 12'd255};
    vt[8] = '{12'h000, 1'b0, 12'd255};
    vt[9] = '{12'h000, 1'b0, 12'd255};

    // 1: reset values and startup sequence
    rst = 1'b1; Flt_n = 1'b1; seq_low = 1'b1; vol_in = 12'h100; vld = 1'b0;
    tick(); tick();
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_sht", 32'(sht_dwn), 32'd1);
    chk("rst_mute", 32'(mute), 32'd1);
    chk("rst_vol", 32'(vol_out), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    rst = 1'b0;
    auto_vld = 1'b1;
    e = 0; sht_fall = -1; mute_fall = -1; nsteps = 0; bad = 0; prev = 0;
    while (state_o != 3'd4 && e < 400) begin
      tick();
      e++;
      if (sht_fall < 0 && !sht_dwn) sht_fall = e;
      if (mute_fall < 0 && !mute) mute_fall = e;
      if (int'(vol_out) != prev) begin
        nsteps++;
        if (int'(vol_out) != prev + 16) bad++;
        prev = int'(vol_out);
      end
    end
    chk("startup_sht_fall", 32'(sht_fall), 32'd101);
    chk("settle_to_unmute", 32'(mute_fall - sht_fall), 32'd8);
    chk("ramp_steps", 32'(nsteps), 32'd16);
    chk("ramp_bad_steps", 32'(bad), 32'd0);
    chk("ramp_final_vol", 32'(vol_out), 32'd256);
    chk("ramp_run_state", 32'(state_o), 32'd4);

    // 2: queue gate holds startup until seq_low
    rst = 1'b1; seq_low = 1'b0;
    tick(); tick();
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (!sht_dwn) lows++;
    end
    chk("gate_held", 32'(lows), 32'd0);
    seq_low = 1'b1;
    n = 0;
    while (sht_dwn && n < 10) begin
      tick();
      n++;
    end
    chk("gate_release_lat", 32'(n), 32'd1);
    go_run("gate_run");
    chk("gate_vol", 32'(vol_out), 32'd256);

    // 3: slew table, then full-scale climb without wrap
    auto_vld = 1'b0; vld = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      vol_in = vt[i].vin;
      vld = vt[i].v;
      tick();
      vld = 1'b0;
      chk($sformatf("slew_vec%0d", i), 32'(vol_out), 32'(vt[i].exp_vol));
      chk($sformatf("slew_state%0d", i), 32'(state_o), 32'd4);
    end
    vol_in = 12'hFFF;
    prev = int'(vol_out); n = 0; bad = 0;
    while (vol_out != 12'hFFF && n < 300) begin
      vld = 1'b1; tick(); vld = 1'b0;
      n++;
      if (int'(vol_out) < prev || int'(vol_out) - prev > 16) bad++;
      prev = int'(vol_out);
    end
    chk("slew_up_pulses", 32'(n), 32'd240);
    chk("slew_up_bad", 32'(bad), 32'd0);
    chk("slew_top", 32'(vol_out), 32'd4095);
    vld = 1'b1; tick(); vld = 1'b0;
    chk("slew_sat", 32'(vol_out), 32'd4095);
    vol_in = 12'h000;
    vld = 1'b1; tick(); vld = 1'b0;
    chk("slew_down_top", 32'(vol_out), 32'd4079);
    vol_in = 12'h100;

    // 4: fault, hold-off with bounce, full restart
    auto_vld = 1'b1;
    Flt_n = 1'b0;
    idx = -1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (idx < 0 && sht_dwn && vol_out == 12'd0) idx = i;
    end
    chk("fault_latency", 32'(idx), 32'd3);
    chk("fault_state", 32'(state_o), 32'd5);
    chk("fault_mute", 32'(mute), 32'd1);
    Flt_n = 1'b1;
    repeat (20) tick();
    chk("hold_state", 32'(state_o), 32'd5);
    Flt_n = 1'b0; tick(); Flt_n = 1'b1;
    n = 0;
    while (state_o == 3'd5 && n < 200) begin
      tick();
      n++;
    end
    chk("hold_bounce_cycles", 32'(n), 32'd52);
    chk("hold_exit_state", 32'(state_o), 32'd1);
    n = 0;
    while (sht_dwn && n < 300) begin
      tick();
      n++;
    end
    chk("restart_delay", 32'(n), 32'd100);
    go_run("refault_run");
    chk("refault_vol", 32'(vol_out), 32'd256);

    // 5: lockout after three close faults; reset mid-run and from lock
    rst = 1'b1; tick();
    chk("rst_run_state", 32'(state_o), 32'd0);
    chk("rst_run_vol", 32'(vol_out), 32'd0);
    chk("rst_run_sht", 32'(sht_dwn), 32'd1);
    rst = 1'b0;
    go_run("lock_run1");
    do_fault(s); chk("lock_f1", 32'(s), 32'd1);
    go_run("lock_run2");
    do_fault(s); chk("lock_f2", 32'(s), 32'd1);
    go_run("lock_run3");
    do_fault(s); chk("lock_f3", 32'(s), 32'd6);
    chk("lock_flag", 32'(locked), 32'd1);
    chk("lock_sht", 32'(sht_dwn), 32'd1);
    chk("lock_vol", 32'(vol_out), 32'd0);
    lows = 0;
    repeat (1000) begin
      tick();
      if (state_o != 3'd6 || !locked) lows++;
    end
    chk("lock_hold", 32'(lows), 32'd0);
    rst = 1'b1; tick();
    chk("lock_rst_state", 32'(state_o), 32'd0);
    chk("lock_rst_flag", 32'(locked), 32'd0);
    rst = 1'b0; tick();
    chk("lock_rst_wait", 32'(state_o), 32'd1);

    // 6: long clean run clears retry history
    go_run("clr_run1");
    do_fault(s); chk("clr_f1", 32'(s), 32'd1);
    go_run("clr_run2");
    do_fault(s); chk("clr_f2", 32'(s), 32'd1);
    go_run("clr_run3");
    repeat (450) tick();
    chk("clr_run_kept", 32'(state_o), 32'd4);
    do_fault(s); chk("clr_f3", 32'(s), 32'd1);
    go_run("clr_run4");
    do_fault(s); chk("clr_f4", 32'(s), 32'd1);
    go_run("clr_run5");
    chk("clr_not_locked", 32'(locked), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
